// File: rtl/sample_tx_pkg.sv
// Shared types and constants for the sample-to-byte output path.
// Includes the handshake FSM states, byte-count helper and uio pin positions.
package sample_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_t;

    // Bit positions of the handshake signals on the bidirectional uio pins.
    localparam int UIO_STROBE_BIT = 0;
    localparam int UIO_LAST_BIT   = 1;
    localparam int UIO_ACK_BIT    = 2;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers and a show-ahead head word.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers match in address bits; the wrap bit tells full from empty.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sample_byte_tx.sv
// Buffers WIDTH-bit samples and sends them MSB byte first to an external host
// over a 4-phase strobe/ack handshake with a synchronized acknowledge.
module sample_byte_tx
    import sample_tx_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [7:0]             tx_byte,
    output logic                   tx_strobe,
    output logic                   tx_last,
    input  logic                   tx_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy
);

    localparam int BYTES = bytes_of(WIDTH);
    localparam int IDX_W = $clog2(BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       w_shift_next;
    logic [WIDTH-1:0]       w_shift_adv;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [7:0]             r_tx_byte;
    logic [7:0]             w_tx_byte_next;
    logic                   r_tx_strobe;
    logic                   r_tx_last;
    logic                   r_ack_meta;
    logic                   r_ack_s;
    logic                   w_push;
    logic                   w_pop;
    logic [WIDTH-1:0]       w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;

    assign w_push = s_valid && !w_full;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // tx_ack comes straight from a pin; only r_ack_s may steer the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= tx_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    assign w_shift_adv = r_shift << 8;

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_idx_next     = r_idx;
        w_tx_byte_next = r_tx_byte;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_idx_next     = '0;
                    w_tx_byte_next = w_head[WIDTH-1 -: 8];
                    w_state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // Wait out a host that is still holding ack from before.
                if (!r_ack_s) begin
                    w_state_next = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (r_ack_s) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!r_ack_s) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_next     = r_idx + IDX_W'(1);
                        w_shift_next   = w_shift_adv;
                        w_tx_byte_next = w_shift_adv[WIDTH-1 -: 8];
                        w_state_next   = ST_SETUP;
                    end else if (!w_empty) begin
                        w_pop          = 1'b1;
                        w_shift_next   = w_head;
                        w_idx_next     = '0;
                        w_tx_byte_next = w_head[WIDTH-1 -: 8];
                        w_state_next   = ST_SETUP;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_tx_byte   <= 8'h00;
            r_tx_strobe <= 1'b0;
            r_tx_last   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_idx       <= w_idx_next;
            r_tx_byte   <= w_tx_byte_next;
            r_tx_strobe <= (w_state_next == ST_STROBE);
            r_tx_last   <= (w_state_next != ST_IDLE) && (w_idx_next == LAST_IDX);
        end
    end

    assign s_ready   = !w_full;
    assign tx_byte   = r_tx_byte;
    assign tx_strobe = r_tx_strobe;
    assign tx_last   = r_tx_last;
    assign count     = w_count;
    assign busy      = (r_state != ST_IDLE) || (w_count != '0);

endmodule

// File: tb/tb_sample_byte_tx.sv
// Self-checking bench: a manual host handshake plus a queue model of the
// expected byte stream (each sample split MSB first, last flag on final byte).
module tb_sample_byte_tx;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [7:0]       tx_byte;
    logic             tx_strobe;
    logic             tx_last;
    logic             tx_ack = 1'b0;
    logic [CW-1:0]    count;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_b[$];
    bit         exp_l[$];

    sample_byte_tx #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .tx_byte   (tx_byte),
        .tx_strobe (tx_strobe),
        .tx_last   (tx_last),
        .tx_ack    (tx_ack),
        .count     (count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Reference model: a sample becomes BYTES bytes, most significant first.
    task automatic model_add(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        for (int k = 0; k < BYTES; k++) begin
            t = s >> (8 * (BYTES - 1 - k));
            exp_b.push_back(t[7:0]);
            exp_l.push_back(k == BYTES - 1);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_b.delete();
        exp_l.delete();
    endtask

    // Called and returns just after a falling edge.
    task automatic push(input logic [WIDTH-1:0] d, output bit ok);
        int guard;
        guard   = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        ok = (s_ready === 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        $display("[TB] push %h", d);
    endtask

    // One host handshake: wait strobe, hold for delay cycles, ack, release.
    task automatic host_xfer(input int delay, output logic [7:0] b, output logic l,
                             output bit stable, output int fall, output bit ok);
        int guard;
        guard  = 0;
        stable = 1'b1;
        fall   = 0;
        ok     = 1'b1;
        while (tx_strobe !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (tx_strobe !== 1'b1) begin
            ok = 1'b0;
            b  = 8'hxx;
            l  = 1'bx;
            return;
        end
        b = tx_byte;
        l = tx_last;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (tx_byte !== b || tx_strobe !== 1'b1) stable = 1'b0;
        end
        tx_ack = 1'b1;
        while (tx_strobe === 1'b1 && fall < 50) begin
            @(negedge clk);
            fall++;
            if (tx_byte !== b) stable = 1'b0;
        end
        ok     = (tx_strobe === 1'b0);
        tx_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (tx_byte !== b || tx_strobe !== 1'b0) stable = 1'b0;
        end
        $display("[TB] byte %h last %0b", b, l);
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (tx_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", tx_strobe); end
        n_tests++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", tx_last); end
        n_tests++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", tx_byte); end
        n_tests++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", s_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        bit ok, st;
        logic [7:0] b;
        logic l;
        int fall;
        apply_reset();
        tx_ack = 1'b0;
        push(16'hA55A, ok);
        n_tests++; if (count !== CW'(1) || busy !== 1'b1) begin n_fail++; $display("FAIL single_push count/busy got %0d/%b want 1/1", count, busy); end
        @(negedge clk);
        n_tests++; if (count !== CW'(0) || tx_strobe !== 1'b0 || tx_byte !== 8'hA5) begin
            n_fail++; $display("FAIL single_setup count/strobe/byte got %0d/%b/%h want 0/0/a5", count, tx_strobe, tx_byte); end
        @(negedge clk);
        n_tests++; if (tx_strobe !== 1'b1) begin n_fail++; $display("FAIL single_strobe_rise got %b want 1", tx_strobe); end
        host_xfer(0, b, l, st, fall, ok);
        n_tests++; if (!ok || b !== 8'hA5 || l !== 1'b0) begin n_fail++; $display("FAIL single_byte0 got %h/%b want a5/0", b, l); end
        host_xfer(0, b, l, st, fall, ok);
        n_tests++; if (!ok || b !== 8'h5A || l !== 1'b1) begin n_fail++; $display("FAIL single_byte1 got %h/%b want 5a/1", b, l); end
        n_tests++; if (fall !== 3) begin n_fail++; $display("FAIL single_ack_to_fall got %0d edges want 3", fall); end
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || tx_last !== 1'b0) begin n_fail++; $display("FAIL single_idle busy/last got %b/%b want 0/0", busy, tx_last); end
    endtask

    task automatic test_fill();
        bit ok, st;
        logic [7:0] b, eb;
        logic l, el;
        int fall, guard;
        apply_reset();
        tx_ack = 1'b0;
        for (int i = 1; i <= 6; i++) model_add(WIDTH'(i));
        for (int i = 1; i <= 5; i++) push(WIDTH'(i), ok);
        n_tests++; if (count !== CW'(4) || s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full count/ready got %0d/%b want 4/0", count, s_ready); end
        s_data  = WIDTH'(6);
        s_valid = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_held_off count got %0d want 4", count); end
        for (int k = 0; k < BYTES; k++) begin
            host_xfer(0, b, l, st, fall, ok);
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL fill_byte got %h/%b want %h/%b", b, l, eb, el); end
        end
        guard = 0;
        while (s_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        s_valid = 1'b0;
        n_tests++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_sixth_accepted count got %0d want 4", count); end
        while (exp_b.size() > 0) begin
            host_xfer($urandom_range(0, 2), b, l, st, fall, ok);
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL fill_byte got %h/%b want %h/%b", b, l, eb, el); end
        end
    endtask

    task automatic test_slow_host();
        bit ok, st;
        logic [7:0] b, eb;
        logic l, el;
        int fall;
        logic [WIDTH-1:0] s;
        apply_reset();
        tx_ack = 1'b0;
        s = WIDTH'($urandom);
        model_add(s);
        push(s, ok);
        for (int k = 0; k < BYTES; k++) begin
            host_xfer(10, b, l, st, fall, ok);
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL slow_byte got %h/%b want %h/%b", b, l, eb, el); end
            n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL slow_stable got %b want 1", st); end
            n_tests++; if (fall !== 3) begin n_fail++; $display("FAIL slow_ack_to_fall got %0d edges want 3", fall); end
        end
    endtask

    task automatic test_ack_across_reset();
        bit ok, st;
        logic [7:0] b, eb;
        logic l, el;
        int fall, n, seen;
        logic [WIDTH-1:0] s;
        tx_ack = 1'b1;
        apply_reset();
        s = WIDTH'($urandom);
        model_add(s);
        push(s, ok);
        seen = 0;
        repeat (8) begin @(negedge clk); if (tx_strobe === 1'b1) seen++; end
        n_tests++; if (seen !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL ackrst_held strobes/busy got %0d/%b want 0/1", seen, busy); end
        n_tests++; if (tx_byte !== exp_b[0]) begin n_fail++; $display("FAIL ackrst_byte got %h want %h", tx_byte, exp_b[0]); end
        tx_ack = 1'b0;
        n = 0;
        while (tx_strobe !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_tests++; if (n !== 3) begin n_fail++; $display("FAIL ackrst_release_to_strobe got %0d edges want 3", n); end
        for (int k = 0; k < BYTES; k++) begin
            host_xfer(0, b, l, st, fall, ok);
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL ackrst_byte got %h/%b want %h/%b", b, l, eb, el); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int guard, seen;
        apply_reset();
        tx_ack = 1'b0;
        push(16'hBEEF, ok);
        push(16'h1234, ok);
        guard = 0;
        while (tx_strobe !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        n_tests++; if (tx_strobe !== 1'b1 || tx_byte !== 8'hBE) begin n_fail++; $display("FAIL mid_strobe strobe/byte got %b/%h want 1/be", tx_strobe, tx_byte); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (tx_strobe !== 1'b0 || count !== CW'(0) || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset strobe/count/ready got %b/%0d/%b want 0/0/1", tx_strobe, count, s_ready); end
        rst = 1'b0;
        seen = 0;
        repeat (20) begin @(negedge clk); if (tx_strobe === 1'b1) seen++; end
        n_tests++; if (seen !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_quiet strobes/busy got %0d/%b want 0/0", seen, busy); end
    endtask

    task automatic test_back_to_back();
        bit ok, st;
        logic [7:0] b, eb;
        logic l, el;
        int fall;
        logic [WIDTH-1:0] s [8];
        apply_reset();
        tx_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i] = WIDTH'($urandom);
            model_add(s[i]);
        end
        for (int i = 0; i < 3; i++) push(s[i], ok);
        n_tests++; if (count !== CW'(2)) begin n_fail++; $display("FAIL b2b_prefill count got %0d want 2", count); end
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < BYTES; k++) begin
                host_xfer(0, b, l, st, fall, ok);
                eb = exp_b.pop_front(); el = exp_l.pop_front();
                n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL b2b_byte got %h/%b want %h/%b", b, l, eb, el); end
            end
            // This edge pops the next sample; push into it at the same time.
            s_data  = s[3 + it];
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            n_tests++; if (count !== CW'(2)) begin n_fail++; $display("FAIL b2b_push_pop count got %0d want 2", count); end
            n_tests++; if (tx_byte !== exp_b[0] || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle byte/busy got %h/%b want %h/1", tx_byte, busy, exp_b[0]); end
        end
        while (exp_b.size() > 0) begin
            host_xfer(0, b, l, st, fall, ok);
            eb = exp_b.pop_front(); el = exp_l.pop_front();
            n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL b2b_byte got %h/%b want %h/%b", b, l, eb, el); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] s [12];
        apply_reset();
        tx_ack = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s[i] = WIDTH'($urandom);
            model_add(s[i]);
        end
        fork
            begin
                bit pok;
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 6)) @(negedge clk);
                    push(s[i], pok);
                    n_tests++; if (!pok) begin n_fail++; $display("FAIL rand_push_timeout got stall want accept"); end
                end
            end
            begin
                bit ok, st;
                logic [7:0] b, eb;
                logic l, el;
                int fall;
                for (int n = 0; n < 12 * BYTES; n++) begin
                    host_xfer($urandom_range(0, 4), b, l, st, fall, ok);
                    eb = exp_b.pop_front(); el = exp_l.pop_front();
                    n_tests++; if (!ok || b !== eb || l !== el) begin n_fail++; $display("FAIL rand_byte got %h/%b want %h/%b", b, l, eb, el); end
                    n_tests++; if (st !== 1'b1) begin n_fail++; $display("FAIL rand_stable got %b want 1", st); end
                end
            end
        join
        repeat (4) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || count !== CW'(0)) begin n_fail++; $display("FAIL rand_drained busy/count got %b/%0d want 0/0", busy, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_slow_host();
        test_ack_across_reset();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
